// File: rtl/ofifo_drain_ctrl_if.sv
// Bundle of start/row-count controls, ofifo read port and psum SRAM write port
// for ofifo_drain_ctrl; slave is the drain sequencer, master is its environment.
interface ofifo_drain_ctrl_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_BW = 11,
    parameter int ROW_BW  = 7
);
    logic                     start;
    logic [ROW_BW-1:0]        num_rows;
    logic [ADDR_BW-1:0]       base_addr;
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic                     sram_we;
    logic [ADDR_BW-1:0]       sram_addr;
    logic [psum_bw*col-1:0]   sram_din;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, num_rows, base_addr, ofifo_valid, ofifo_out,
        output ofifo_rd, sram_we, sram_addr, sram_din, busy, done
    );

    modport master (
        output start, num_rows, base_addr, ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_we, sram_addr, sram_din, busy, done
    );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// Drains complete rows from the systolic-array ofifo into consecutive psum SRAM
// addresses. Optional macro OFIFO_RELU_EN clamps negative lanes to zero on write.
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int ADDR_BW = 11,
    parameter int ROW_BW  = 7,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    ofifo_drain_ctrl_if.slave  bus
);
    localparam int ROW_W = psum_bw * col;
    localparam logic [ROW_BW-1:0]  ROW_ONE  = {{(ROW_BW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BW-1:0] ADDR_ONE = {{(ADDR_BW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    logic [ROW_BW-1:0]   num_rows_r;
    logic [ROW_BW-1:0]   issued_r;
    logic [ROW_BW-1:0]   wr_cnt_r;
    logic [ADDR_BW-1:0]  wr_addr_r;
    logic [RD_LAT-1:0]   pipe_r;
    logic                ofifo_rd_r;
    logic                sram_we_r;
    logic [ADDR_BW-1:0]  sram_addr_r;
    logic [ROW_W-1:0]    sram_din_r;
    logic                busy_r;
    logic                done_r;
    logic                issue_s;
    logic                capture_s;

    // Row shaping applied between the ofifo capture and the SRAM data register.
    function automatic logic [ROW_W-1:0] shape_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] res;
        res = row;
`ifdef OFIFO_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (row[i*psum_bw + psum_bw - 1]) begin
                res[i*psum_bw +: psum_bw] = {psum_bw{1'b0}};
            end else begin
                res[i*psum_bw +: psum_bw] = row[i*psum_bw +: psum_bw];
            end
        end
`endif
        return res;
    endfunction

    // Read issue: only one read outstanding, so a stale ofifo_valid cannot over-read.
    always_comb begin
        issue_s = 1'b0;
        if ((state_r == DRAIN) && bus.ofifo_valid && (issued_r < num_rows_r) &&
            (pipe_r == {RD_LAT{1'b0}})) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    assign capture_s = pipe_r[RD_LAT-1];

    // Sequencer FSM, in-flight read pipeline and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            num_rows_r  <= {ROW_BW{1'b0}};
            issued_r    <= {ROW_BW{1'b0}};
            wr_cnt_r    <= {ROW_BW{1'b0}};
            wr_addr_r   <= {ADDR_BW{1'b0}};
            pipe_r      <= {RD_LAT{1'b0}};
            ofifo_rd_r  <= 1'b0;
            sram_we_r   <= 1'b0;
            sram_addr_r <= {ADDR_BW{1'b0}};
            sram_din_r  <= {ROW_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ofifo_rd_r <= issue_s;
            pipe_r[0]  <= issue_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end

            if (capture_s) begin
                sram_we_r   <= 1'b1;
                sram_addr_r <= wr_addr_r;
                sram_din_r  <= shape_row(bus.ofifo_out);
                wr_addr_r   <= wr_addr_r + ADDR_ONE;
                wr_cnt_r    <= wr_cnt_r + ROW_ONE;
            end else begin
                sram_we_r   <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        num_rows_r <= bus.num_rows;
                        wr_addr_r  <= bus.base_addr;
                        issued_r   <= {ROW_BW{1'b0}};
                        wr_cnt_r   <= {ROW_BW{1'b0}};
                        busy_r     <= 1'b1;
                        if (bus.num_rows == {ROW_BW{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (issue_s) begin
                        issued_r <= issued_r + ROW_ONE;
                        if ((issued_r + ROW_ONE) == num_rows_r) begin
                            state_r <= FLUSH;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                FLUSH: begin
                    // Completion lands one cycle after the final SRAM write pulse.
                    if ((pipe_r == {RD_LAT{1'b0}}) && (wr_cnt_r == num_rows_r)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= FLUSH;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ofifo_rd  = ofifo_rd_r;
    assign bus.sram_we   = sram_we_r;
    assign bus.sram_addr = sram_addr_r;
    assign bus.sram_din  = sram_din_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
endmodule
